delay_timer_arbiter: RTL and testbench

//   Shares one down-counting delay timer among N_REQ requesters. Arbitration is round-robin.

---
 rtl/delay_timer_arbiter.sv | 141 ++++++++++++++
 tb/tb_delay_timer_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_timer_arbiter.sv
// Round-robin arbiter sharing one down-counting delay timer among N_REQ requesters.
// A granted requester has its delay loaded, counted down to zero, then receives a done pulse.
module delay_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   delay,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [WIDTH-1:0]         count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_ptr_next;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   winner_next;
  logic [IDX_W-1:0]   after_winner;
  logic [N_REQ-1:0]   gnt_next;
  logic [N_REQ-1:0]   done_next;
  logic [WIDTH-1:0]   count_next;
  logic               busy_next;

  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   scan_idx;
  logic [WIDTH-1:0]   load_delay;

  // First requester at or above rr_ptr, wrapping around modulo N_REQ.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = IDX_W'((int'(rr_ptr) + i) % N_REQ);
      if (!pick_valid && req[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    load_delay = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        load_delay = delay[i*WIDTH +: WIDTH];
      end
    end
  end

  assign after_winner = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);

  always_comb begin
    state_next  = state;
    gnt_next    = gnt;
    done_next   = '0;
    count_next  = count;
    rr_ptr_next = rr_ptr;
    winner_next = winner;

    case (state)
      IDLE: begin
        gnt_next = '0;
        if (pick_valid) begin
          state_next  = RUN;
          winner_next = pick;
          gnt_next    = N_REQ'(1) << pick;
          count_next  = load_delay;
        end
      end

      RUN: begin
        // A dropped request abandons the service silently; the pointer still moves past it.
        if (!req[winner]) begin
          state_next  = IDLE;
          gnt_next    = '0;
          count_next  = '0;
          rr_ptr_next = after_winner;
        end else if (count != '0) begin
          count_next = count - WIDTH'(1);
        end else begin
          state_next = DONE;
          done_next  = gnt;
        end
      end

      DONE: begin
        state_next  = IDLE;
        gnt_next    = '0;
        rr_ptr_next = after_winner;
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      count  <= '0;
      rr_ptr <= '0;
      winner <= '0;
    end else begin
      state  <= state_next;
      gnt    <= gnt_next;
      done   <= done_next;
      busy   <= busy_next;
      count  <= count_next;
      rr_ptr <= rr_ptr_next;
      winner <= winner_next;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_done_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(done));
  a_done_matches_gnt: assert property (@(posedge clk) disable iff (rst) (done != '0) |-> (done == gnt));
  a_busy_tracks_gnt: assert property (@(posedge clk) disable iff (rst) busy == (gnt != '0));

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Self-checking bench for delay_timer_arbiter: directed scenarios plus randomized service
// sequences checked against a transaction-level round-robin model.
module tb_delay_timer_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   delay;
  logic [N-1:0]     gnt;
  logic [N-1:0]     done;
  logic             busy;
  logic [W-1:0]     count;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  delay_timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .delay (delay),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return delay[i*W +: W];
  endfunction

  task automatic set_lane(input int i, input logic [W-1:0] v);
    delay[i*W +: W] = v;
  endtask

  // Round-robin model: first requester at or after ptr, wrapping.
  function automatic int pick_winner(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (((r >> ((ptr + i) % N)) & N'(1)) != '0) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    req   = '0;
    delay = '0;
    step();
    step();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // One complete service of the model's predicted winner, starting in an IDLE cycle.
  task automatic serve(input logic [N-1:0] next_req, input bit jitter, input string tag);
    int w;
    int d;
    logic [N-1:0] oh;
    w = pick_winner(req, model_ptr);
    n_checks++;
    if (w < 0) begin
      n_fail++;
      $display("FAIL %s_setup: req=%b has no requester, required a pending request", tag, req);
      return;
    end
    d  = int'(lane(w));
    oh = N'(1) << w;

    step();
    n_checks++;
    if (gnt !== oh || count !== W'(d) || busy !== 1'b1 || done !== '0) begin
      n_fail++;
      $display("FAIL %s_grant: gnt=%b count=%0d busy=%b done=%b, required gnt=%b count=%0d busy=1 done=0",
               tag, gnt, count, busy, done, oh, d);
    end

    for (int k = 1; k <= d; k++) begin
      if (jitter) begin
        for (int i = 0; i < N; i++) set_lane(i, W'($urandom_range(0, 20)));
        req = N'($urandom) | oh;
      end
      step();
      n_checks++;
      if (count !== W'(d - k) || done !== '0 || gnt !== oh) begin
        n_fail++;
        $display("FAIL %s_count: count=%0d done=%b gnt=%b, required count=%0d done=0 gnt=%b",
                 tag, count, done, gnt, d - k, oh);
      end
    end

    step();
    n_checks++;
    if (done !== oh || gnt !== oh || count !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: done=%b gnt=%b count=%0d busy=%b, required done=%b gnt=%b count=0 busy=1",
               tag, done, gnt, count, busy, oh, oh);
    end
    req = next_req;

    step();
    n_checks++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_release: gnt=%b done=%b busy=%b, required gnt=0 done=0 busy=0",
               tag, gnt, done, busy);
    end
    model_ptr = (w + 1) % N;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt !== '0 || done !== '0 || busy !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b done=%b busy=%b count=%0d, required all zero",
               gnt, done, busy, count);
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_activity;
    do_reset();
    set_lane(1, 8'd8);
    req = 4'b0010;
    step();
    step();
    step();
    step();
    n_checks++;
    if (gnt !== 4'b0010 || count !== 8'd5) begin
      n_fail++;
      $display("FAIL midrun_setup: gnt=%b count=%0d, required gnt=0010 count=5", gnt, count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (gnt !== '0 || busy !== 1'b0 || count !== '0 || done !== '0) begin
      n_fail++;
      $display("FAIL midrun_async_reset: gnt=%b busy=%b count=%0d done=%b, required all zero",
               gnt, busy, count, done);
    end
    req = '0;
    step();
    rst = 1'b0;
    model_ptr = 0;
    saw_activity = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== '0 || gnt !== '0) saw_activity = 1'b1;
    end
    n_checks++;
    if (saw_activity !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_no_done: activity=%b, required 0", saw_activity);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_lane(0, 8'd3);
    req = 4'b0001;
    serve(4'b0000, 1'b0, "single");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 8'd1);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) serve(4'b0101, 1'b0, "rr_pair");
    serve(4'b1111, 1'b0, "rr_pair");
    for (int i = 0; i < 3; i++) serve(4'b1111, 1'b0, "rr_all");
    serve(4'b0000, 1'b0, "rr_all");
  endtask

  task automatic test_boundary_delays();
    do_reset();
    set_lane(3, 8'd0);
    req = 4'b1000;
    serve(4'b0000, 1'b0, "delay_zero");
    set_lane(3, 8'd255);
    req = 4'b1000;
    serve(4'b0000, 1'b0, "delay_max");
  endtask

  task automatic test_abort();
    do_reset();
    set_lane(0, 8'd10);
    set_lane(1, 8'd3);
    req = 4'b0001;
    step();
    n_checks++;
    if (gnt !== 4'b0001 || count !== 8'd10) begin
      n_fail++;
      $display("FAIL abort_grant: gnt=%b count=%0d, required gnt=0001 count=10", gnt, count);
    end
    req = 4'b0011;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (gnt !== 4'b0001 || count !== 8'd6) begin
      n_fail++;
      $display("FAIL abort_pre: gnt=%b count=%0d, required gnt=0001 count=6", gnt, count);
    end
    req = 4'b0010;
    step();
    n_checks++;
    if (gnt !== '0 || count !== '0 || done !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: gnt=%b count=%0d done=%b busy=%b, required all zero",
               gnt, count, done, busy);
    end
    model_ptr = 1;
    serve(4'b0000, 1'b0, "abort_next");
  endtask

  task automatic test_delay_change();
    do_reset();
    set_lane(0, 8'd4);
    req = 4'b0001;
    step();
    n_checks++;
    if (gnt !== 4'b0001 || count !== 8'd4) begin
      n_fail++;
      $display("FAIL dchg_grant: gnt=%b count=%0d, required gnt=0001 count=4", gnt, count);
    end
    step();
    step();
    set_lane(0, 8'd9);
    for (int i = 3; i <= 5; i++) begin
      step();
      n_checks++;
      if (i < 5 && done !== '0) begin
        n_fail++;
        $display("FAIL dchg_early: cycle=%0d done=%b, required done=0", i, done);
      end else if (i == 5 && (done !== 4'b0001 || count !== '0)) begin
        n_fail++;
        $display("FAIL dchg_done: done=%b count=%0d, required done=0001 count=0", done, count);
      end
    end
    req = '0;
    step();
    n_checks++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL dchg_release: gnt=%b busy=%b, required gnt=0 busy=0", gnt, busy);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, W'($urandom_range(0, 15)));
    r = '0;
    while (r == '0) r = N'($urandom);
    req = r;
    for (int t = 0; t < 25; t++) begin
      r = '0;
      while (r == '0) r = N'($urandom);
      serve(r, 1'b1, "random");
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    delay = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_boundary_delays();
    test_abort();
    test_delay_change();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
